// File: rtl/atmega_pio_pkg.sv
// rtl/atmega_pio_pkg.sv - shared constants, edge modes and helpers for the ATMEGA-style PIO
package atmega_pio_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned OFF_PORT_OUT   = 'h20;
  localparam int unsigned OFF_PORT_CLEAR = 'h00;
  localparam int unsigned OFF_PORT_SET   = 'h01;
  localparam int unsigned OFF_DDR        = 'h23;
  localparam int unsigned OFF_PIN        = 'h24;
  localparam int unsigned OFF_RISE       = 'h25;
  localparam int unsigned OFF_FALL       = 'h26;
  localparam int unsigned OFF_FLAG       = 'h27;

  // Wider ports occupy more bus bytes, so low address bits are ignored in decode.
  function automatic int addr_shift(input int port_width);
    if (port_width > 16) return 2;
    else if (port_width > 8) return 1;
    else return 0;
  endfunction

  function automatic logic edge_hit(input edge_mode_e mode, input logic cur, input logic prev);
    return (cur & ~prev & mode[0]) | (~cur & prev & mode[1]);
  endfunction

endpackage

// File: rtl/pio_sync2.sv
// rtl/pio_sync2.sv - two-flop synchroniser for asynchronous pad inputs
module pio_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/atmega_pio_pcint.sv
// rtl/atmega_pio_pcint.sv - PORT/DDR/PIN register block with edge-selectable pin-change interrupt
module atmega_pio_pcint
  import atmega_pio_pkg::*;
#(
  parameter              PLATFORM             = "XILINX",
  parameter int          BUS_ADDR_DATA_LEN    = 8,
  parameter int          PORT_WIDTH           = 8,
  parameter              USE_CLEAR_SET        = "TRUE",
  parameter              USE_PIN_TOGGLE       = "TRUE",
  parameter int unsigned PORT_OUT_ADDR        = OFF_PORT_OUT,
  parameter int unsigned PORT_CLEAR_ADDR      = OFF_PORT_CLEAR,
  parameter int unsigned PORT_SET_ADDR        = OFF_PORT_SET,
  parameter int unsigned DDR_ADDR             = OFF_DDR,
  parameter int unsigned PIN_ADDR             = OFF_PIN,
  parameter int unsigned RISE_ADDR            = OFF_RISE,
  parameter int unsigned FALL_ADDR            = OFF_FALL,
  parameter int unsigned FLAG_ADDR            = OFF_FLAG,
  parameter logic [31:0] PINMASK              = 32'hFF,
  parameter logic [31:0] PULLUP_MASK          = 32'h0,
  parameter logic [31:0] PULLDN_MASK          = 32'h0,
  parameter logic [31:0] INVERSE_MASK         = 32'h0,
  parameter logic [31:0] OUT_ENABLED_MASK     = 32'hFF,
  parameter logic [31:0] INITIAL_OUTPUT_VALUE = 32'h00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [PORT_WIDTH-1:0]        bus_in,
  output logic [PORT_WIDTH-1:0]        bus_out,
  input  logic [PORT_WIDTH-1:0]        io_in,
  output wire  [PORT_WIDTH-1:0]        io_out,
  output logic [PORT_WIDTH-1:0]        pio_out_io_connect,
  output logic                         irq,
  input  logic                         irq_ack
);

  localparam int AW    = BUS_ADDR_DATA_LEN;
  localparam int PW    = PORT_WIDTH;
  localparam int SHIFT = addr_shift(PORT_WIDTH);
  localparam logic [PW-1:0] PMASK = PINMASK[PW-1:0];
  localparam logic [PW-1:0] INV   = INVERSE_MASK[PW-1:0] & PINMASK[PW-1:0];
  localparam logic [PW-1:0] OEN   = OUT_ENABLED_MASK[PW-1:0] & PINMASK[PW-1:0];
  localparam logic [PW-1:0] INIT  = INITIAL_OUTPUT_VALUE[PW-1:0] & PINMASK[PW-1:0];
  localparam bit HAS_CS  = (USE_CLEAR_SET == "TRUE");
  localparam bit HAS_TGL = (USE_PIN_TOGGLE == "TRUE");

  logic [AW-1:0] waddr;
  logic sel_port, sel_clr, sel_set, sel_ddr, sel_pin, sel_rise, sel_fall, sel_flag;

  assign waddr    = addr >> SHIFT;
  assign sel_port = (waddr == AW'(PORT_OUT_ADDR));
  assign sel_clr  = (waddr == AW'(PORT_CLEAR_ADDR));
  assign sel_set  = (waddr == AW'(PORT_SET_ADDR));
  assign sel_ddr  = (waddr == AW'(DDR_ADDR));
  assign sel_pin  = (waddr == AW'(PIN_ADDR));
  assign sel_rise = (waddr == AW'(RISE_ADDR));
  assign sel_fall = (waddr == AW'(FALL_ADDR));
  assign sel_flag = (waddr == AW'(FLAG_ADDR));

  logic [PW-1:0] port_q, port_d, ddr_q, ddr_d, pin_q, pin_d;
  logic [PW-1:0] rise_q, rise_d, fall_q, fall_d, flag_q, flag_d;
  logic [PW-1:0] v_prev_q, v_prev_d;
  logic          irq_q, irq_d;
  logic [PW-1:0] pin_sync, v_cur, hit, flag_clr;

  pio_sync2 #(.WIDTH(PW)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (io_in),
    .q_o   (pin_sync)
  );

  // Edges are detected on the polarity-corrected pin value so INVERSE_MASK swaps rise/fall sense.
  assign v_cur = (pin_q ^ INV) & PMASK;

  always_comb begin
    port_d   = port_q;
    ddr_d    = ddr_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    flag_clr = '0;
    hit      = '0;
    if (wr) begin
      if (sel_port)                port_d = bus_in;
      else if (HAS_CS && sel_clr)  port_d = port_q & ~bus_in;
      else if (HAS_CS && sel_set)  port_d = port_q | bus_in;
      else if (HAS_TGL && sel_pin) port_d = port_q ^ bus_in;
      if (sel_ddr)  ddr_d    = bus_in;
      if (sel_rise) rise_d   = bus_in;
      if (sel_fall) fall_d   = bus_in;
      if (sel_flag) flag_clr = bus_in;
    end
    if (irq_ack) flag_clr = '1;
    for (int i = 0; i < PW; i++) begin
      hit[i] = edge_hit(edge_mode_e'({fall_q[i], rise_q[i]}), v_cur[i], v_prev_q[i]);
    end
    // Set after clear: a fresh edge survives a same-cycle W1C or ack.
    flag_d   = ((flag_q & ~flag_clr) | hit) & PMASK;
    port_d   = port_d & PMASK;
    ddr_d    = ddr_d & PMASK;
    rise_d   = rise_d & PMASK;
    fall_d   = fall_d & PMASK;
    pin_d    = pin_sync & PMASK;
    v_prev_d = v_cur;
    irq_d    = |flag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q   <= INIT;
      ddr_q    <= '0;
      pin_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      flag_q   <= '0;
      v_prev_q <= INV;
      irq_q    <= 1'b0;
    end else begin
      port_q   <= port_d;
      ddr_q    <= ddr_d;
      pin_q    <= pin_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      flag_q   <= flag_d;
      v_prev_q <= v_prev_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    bus_out = '0;
    if (rd) begin
      if (sel_port)      bus_out = port_q;
      else if (sel_ddr)  bus_out = ddr_q;
      else if (sel_pin)  bus_out = v_cur;
      else if (sel_rise) bus_out = rise_q;
      else if (sel_fall) bus_out = fall_q;
      else if (sel_flag) bus_out = flag_q;
    end
  end

  assign irq                = irq_q;
  assign pio_out_io_connect = ddr_q & OEN;

  for (genvar i = 0; i < PW; i++) begin : g_pad
    assign io_out[i] = pio_out_io_connect[i] ? (port_q[i] ^ INV[i]) : 1'bz;
  end

  if (PLATFORM == "XILINX") begin : g_pull
    for (genvar i = 0; i < PW; i++) begin : g_bit
      if (PULLUP_MASK[i]) begin : g_up
        pullup (io_out[i]);
      end else if (PULLDN_MASK[i]) begin : g_dn
        pulldown (io_out[i]);
      end
    end
  end

endmodule

// File: tb/tb_atmega_pio_pcint.sv
// tb/tb_atmega_pio_pcint.sv - directed bench for atmega_pio_pcint (plain and inverted-bit7 instances)
module tb_atmega_pio_pcint;

  localparam logic [7:0] A_PORT = 8'h20, A_CLR = 8'h00, A_SET = 8'h01, A_DDR = 8'h23;
  localparam logic [7:0] A_PIN = 8'h24, A_RISE = 8'h25, A_FALL = 8'h26, A_FLAG = 8'h27;

  logic       clk, rst, wr, rd, irq_ack;
  logic [7:0] addr, bus_in, io_in;
  logic [7:0] bus_out, bus_out_inv, oe, oe_inv;
  wire  [7:0] io_out, io_out_inv;
  logic       irq, irq_inv;
  logic [7:0] rv, rvi;
  int         vectors = 0;
  int         miscompares = 0;

  atmega_pio_pcint u_dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in), .bus_out(bus_out),
    .io_in(io_in), .io_out(io_out), .pio_out_io_connect(oe), .irq(irq), .irq_ack(irq_ack)
  );

  atmega_pio_pcint #(.INVERSE_MASK(32'h80)) u_inv (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in), .bus_out(bus_out_inv),
    .io_in(io_in), .io_out(io_out_inv), .pio_out_io_connect(oe_inv), .irq(irq_inv), .irq_ack(irq_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    addr = a; bus_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; bus_in = 8'h00; addr = 8'h00;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] d, output logic [7:0] di);
    addr = a; rd = 1'b1;
    #1;
    d = bus_out; di = bus_out_inv;
    rd = 1'b0; addr = 8'h00;
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; rd = 1'b0; irq_ack = 1'b0;
    addr = 8'h00; bus_in = 8'h00; io_in = 8'hFF;

    // Reset held with all pads high
    step(4);
    rd_reg(A_PORT, rv, rvi); check("rst_port", rv, 8'h00);
    rd_reg(A_DDR,  rv, rvi); check("rst_ddr",  rv, 8'h00);
    rd_reg(A_PIN,  rv, rvi); check("rst_pin",  rv, 8'h00);
    rd_reg(A_RISE, rv, rvi); check("rst_rise", rv, 8'h00);
    rd_reg(A_FALL, rv, rvi); check("rst_fall", rv, 8'h00);
    rd_reg(A_FLAG, rv, rvi); check("rst_flag", rv, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_oe", oe, 8'h00);

    step(1);
    rst = 1'b1; io_in = 8'h00;
    step(4);
    rd_reg(A_PIN, rv, rvi); check("pin_idle", rv, 8'h00);

    // Port operations
    wr_reg(A_DDR, 8'hFF);
    wr_reg(A_PORT, 8'hA5);
    wr_reg(A_SET, 8'h0A);
    wr_reg(A_CLR, 8'h81);
    rd_reg(A_PORT, rv, rvi); check("port_setclr", rv, 8'h2E);
    wr_reg(A_PIN, 8'h0F);
    rd_reg(A_PORT, rv, rvi); check("port_toggle", rv, 8'h21);
    check("io_out", io_out, 8'h21);
    check("oe", oe, 8'hFF);
    check("io_out_inv", io_out_inv, 8'hA1);

    // Rising edge on bit 0
    wr_reg(A_RISE, 8'h01);
    io_in = 8'h01;
    step(3);
    rd_reg(A_FLAG, rv, rvi); check("rise_flag_early", rv, 8'h00);
    rd_reg(A_PIN, rv, rvi);  check("rise_pin", rv, 8'h01);
    step(1);
    rd_reg(A_FLAG, rv, rvi); check("rise_flag", rv, 8'h01);
    check("rise_irq_early", irq, 1'b0);
    step(1);
    check("rise_irq", irq, 1'b1);
    io_in = 8'h00;
    step(6);
    rd_reg(A_FLAG, rv, rvi); check("fall_ignored", rv, 8'h01);

    // W1C racing a new edge on the same bit
    wr_reg(A_RISE, 8'h03);
    io_in = 8'h02;
    step(5);
    rd_reg(A_FLAG, rv, rvi); check("w1c_pre", rv, 8'h03);
    io_in = 8'h03;
    step(3);
    wr_reg(A_FLAG, 8'h01);
    rd_reg(A_FLAG, rv, rvi); check("w1c_race", rv, 8'h03);
    wr_reg(A_FLAG, 8'h03);
    rd_reg(A_FLAG, rv, rvi); check("w1c_clear", rv, 8'h00);
    step(1);
    check("w1c_irq", irq, 1'b0);

    // irq_ack on bit 7; inverted instance sees this edge as a fall
    wr_reg(A_RISE, 8'h80);
    io_in = 8'h83;
    step(5);
    rd_reg(A_FLAG, rv, rvi);
    check("ack_pre_flag", rv, 8'h80);
    check("inv_fall_ignored", rvi, 8'h00);
    check("ack_pre_irq", irq, 1'b1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    rd_reg(A_FLAG, rv, rvi); check("ack_flag", rv, 8'h00);
    check("ack_irq_hold", irq, 1'b1);
    step(1);
    check("ack_irq_drop", irq, 1'b0);

    // Raw fall on bit 7: only the inverted instance flags
    io_in = 8'h03;
    step(5);
    rd_reg(A_FLAG, rv, rvi);
    check("inv_main_flag", rv, 8'h00);
    check("inv_flag", rvi, 8'h80);
    rd_reg(A_PIN, rv, rvi);
    check("inv_pin", rvi, 8'h83);

    // Async reset while irq is high
    wr_reg(A_FALL, 8'h01);
    io_in = 8'h02;
    step(6);
    check("pre_reset_irq", irq, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_irq", irq, 1'b0);
    rd_reg(A_FLAG, rv, rvi); check("async_flag", rv, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    rd_reg(A_PORT, rv, rvi); check("post_reset_port", rv, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
